// File: rtl/cic_comb_chain_if.sv
// Sample/result bundle for the CIC comb chain: oversampling select, input samples
// and the scaled, saturated output with its clip flag.
interface cic_comb_chain_if #(
    parameter int IDW = 32,
    parameter int ODW = 16
);
    logic [2:0]            os_sel;
    logic                  in_valid;
    logic signed [IDW-1:0] data_in;
    logic                  out_valid;
    logic signed [ODW-1:0] data_out;
    logic                  sat_flag;

    modport master (
        output os_sel, in_valid, data_in,
        input  out_valid, data_out, sat_flag
    );

    modport slave (
        input  os_sel, in_valid, data_in,
        output out_valid, data_out, sat_flag
    );
endinterface

// File: rtl/cic_comb_chain.sv
// CIC decimator comb section: NSTG registered y[n]=x[n]-x[n-DM] stages, warm-up masking,
// os_sel-dependent right shift and saturation. Define CIC_COMB_ROUND_EN for round-half-up.
module cic_comb_chain #(
    parameter int IDW   = 32,
    parameter int ODW   = 16,
    parameter int NSTG  = 3,
    parameter int DM    = 1,
    parameter int SHMIN = 1
) (
    input  logic              clk_div,
    input  logic              reset_n,
    cic_comb_chain_if.slave   bus
);
    localparam int WARM = NSTG * DM;
    localparam int CW   = $clog2(WARM + 1);
    localparam logic [CW-1:0]         WARM_C = CW'(WARM);
    localparam logic [CW-1:0]         ZERO_C = {CW{1'b0}};
    localparam logic signed [IDW:0]   MAX_C  = {{(IDW-ODW+2){1'b0}}, {(ODW-1){1'b1}}};
    localparam logic signed [IDW:0]   MIN_C  = {{(IDW-ODW+2){1'b1}}, {(ODW-1){1'b0}}};
    localparam logic [IDW:0]          ONE_C  = {{IDW{1'b0}}, 1'b1};

    // Clip to the ODW range; returns {clipped, value}.
    function automatic logic [ODW:0] sat_fn(input logic signed [IDW:0] v);
        logic [ODW:0] r;
        if (v > MAX_C) begin
            r = {1'b1, 1'b0, {(ODW-1){1'b1}}};
        end else if (v < MIN_C) begin
            r = {1'b1, 1'b1, {(ODW-1){1'b0}}};
        end else begin
            r = {1'b0, v[ODW-1:0]};
        end
        return r;
    endfunction

    logic [2:0]            os_r;
    logic [CW-1:0]         warm_r;
    logic signed [IDW-1:0] tap_r   [NSTG][DM];
    logic signed [IDW-1:0] stage_r [NSTG];
    logic [NSTG-1:0]       vld_r, good_r;
    logic                  out_valid_r, sat_flag_r;
    logic signed [ODW-1:0] data_out_r;

    logic                  os_act_s, os_chg_s, accept_s, warm_done_s;
    logic signed [IDW-1:0] x_s [NSTG];
    logic [NSTG-1:0]       v_s, g_s;
    logic [7:0]            shift_s;
    logic signed [IDW:0]   ext_s, rnd_s, shf_s;
    logic [ODW:0]          sat_s;

    // Control decode: activity, select change and sample acceptance.
    always_comb begin
        os_act_s    = (bus.os_sel != 3'b000) && (bus.os_sel != 3'b111);
        os_chg_s    = (bus.os_sel != os_r);
        accept_s    = bus.in_valid && os_act_s && !os_chg_s;
        warm_done_s = (warm_r == ZERO_C);
    end

    // Stage inputs: each stage only moves when its upstream carries a valid sample.
    always_comb begin
        x_s[0] = bus.data_in;
        v_s[0] = accept_s;
        g_s[0] = accept_s && warm_done_s;
        for (int k = 1; k < NSTG; k++) begin
            x_s[k] = stage_r[k-1];
            v_s[k] = vld_r[k-1];
            g_s[k] = good_r[k-1];
        end
    end

    // Output scaling: optional rounding, arithmetic shift by S, saturation.
    always_comb begin
        shift_s = 8'(SHMIN) + (8'(os_r) - 8'd1) * 8'(NSTG);
        ext_s   = {stage_r[NSTG-1][IDW-1], stage_r[NSTG-1]};
`ifdef CIC_COMB_ROUND_EN
        if (shift_s != 8'd0) begin
            rnd_s = ext_s + signed'(ONE_C << (shift_s - 8'd1));
        end else begin
            rnd_s = ext_s;
        end
`else
        rnd_s = ext_s;
`endif
        shf_s = rnd_s >>> shift_s;
        sat_s = sat_fn(shf_s);
    end

    // Comb datapath, valid/warm-up tags and warm-up counter.
    always_ff @(posedge clk_div) begin
        if (!reset_n) begin
            os_r   <= 3'b000;
            warm_r <= WARM_C;
            vld_r  <= {NSTG{1'b0}};
            good_r <= {NSTG{1'b0}};
            for (int k = 0; k < NSTG; k++) begin
                stage_r[k] <= {IDW{1'b0}};
                for (int j = 0; j < DM; j++) tap_r[k][j] <= {IDW{1'b0}};
            end
        end else begin
            os_r <= bus.os_sel;
            if (!os_act_s || os_chg_s) begin
                warm_r <= WARM_C;
                vld_r  <= {NSTG{1'b0}};
                good_r <= {NSTG{1'b0}};
                for (int k = 0; k < NSTG; k++) begin
                    stage_r[k] <= {IDW{1'b0}};
                    for (int j = 0; j < DM; j++) tap_r[k][j] <= {IDW{1'b0}};
                end
            end else begin
                for (int k = 0; k < NSTG; k++) begin
                    if (v_s[k]) begin
                        stage_r[k]  <= x_s[k] - tap_r[k][DM-1];
                        tap_r[k][0] <= x_s[k];
                        for (int j = 1; j < DM; j++) tap_r[k][j] <= tap_r[k][j-1];
                    end
                end
                vld_r  <= v_s;
                good_r <= g_s;
                if (accept_s && !warm_done_s) begin
                    warm_r <= warm_r - CW'(1);
                end
            end
        end
    end

    // Result register: pulses out_valid, otherwise holds data_out/sat_flag.
    always_ff @(posedge clk_div) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            data_out_r  <= {ODW{1'b0}};
            sat_flag_r  <= 1'b0;
        end else if (!os_act_s) begin
            out_valid_r <= 1'b0;
            sat_flag_r  <= 1'b0;
        end else if (os_chg_s) begin
            out_valid_r <= 1'b0;
        end else if (vld_r[NSTG-1] && good_r[NSTG-1]) begin
            out_valid_r <= 1'b1;
            data_out_r  <= sat_s[ODW-1:0];
            sat_flag_r  <= sat_s[ODW];
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.data_out  = data_out_r;
    assign bus.sat_flag  = sat_flag_r;
endmodule

// File: tb/tb_cic_comb_chain.sv
// Directed + randomized bench for cic_comb_chain; reference model works on the sample
// history with a binomial difference formula and a due-cycle result queue.
module tb_cic_comb_chain;
    localparam int IDW = 32, ODW = 16, NSTG = 3, DM = 1, SHMIN = 1;
`ifdef CIC_COMB_ROUND_EN
    localparam int EXP_S4 = 2;
`else
    localparam int EXP_S4 = 1;
`endif

    logic clk_div = 1'b0;
    logic reset_n;
    cic_comb_chain_if #(.IDW(IDW), .ODW(ODW)) bus();

    cic_comb_chain #(.IDW(IDW), .ODW(ODW), .NSTG(NSTG), .DM(DM), .SHMIN(SHMIN)) dut (
        .clk_div (clk_div),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_div = ~clk_div;

    typedef struct {
        int                    due;
        logic signed [ODW-1:0] val;
        logic                  sat;
    } pend_t;

    pend_t                 pend_q[$];
    longint                hist_q[$];
    int                    acc_cnt;
    int                    cyc;
    logic [2:0]            prev_os;
    logic                  exp_v;
    logic signed [ODW-1:0] last_d;
    logic                  last_s;
    logic signed [ODW-1:0] obs_q[$];
    logic                  obs_sat_q[$];
    int                    checks;
    int                    failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // NSTG-th order difference of the recent history, wrapped, scaled and clipped.
    function automatic pend_t model_result(input int due, input logic [2:0] os);
        pend_t                 p;
        longint                acc = 0;
        longint                c = 1;
        longint                v;
        logic signed [IDW-1:0] w;
        int                    n = hist_q.size() - 1;
        int                    s = SHMIN + (int'(os) - 1) * NSTG;
        for (int j = 0; j <= NSTG; j++) begin
            acc = acc + (((j % 2) == 1) ? -c : c) * hist_q[n - j * DM];
            c = c * longint'(NSTG - j) / longint'(j + 1);
        end
        w = acc[IDW-1:0];
        v = longint'(w);
`ifdef CIC_COMB_ROUND_EN
        if (s > 0) v = v + (longint'(1) <<< (s - 1));
`endif
        v = v >>> s;
        p.due = due;
        if (v > ((longint'(1) <<< (ODW - 1)) - 1)) begin
            p.val = {1'b0, {(ODW-1){1'b1}}};
            p.sat = 1'b1;
        end else if (v < -(longint'(1) <<< (ODW - 1))) begin
            p.val = {1'b1, {(ODW-1){1'b0}}};
            p.sat = 1'b1;
        end else begin
            p.val = v[ODW-1:0];
            p.sat = 1'b0;
        end
        return p;
    endfunction

    task automatic step(input logic r, input logic [2:0] os, input logic v, input logic [31:0] d);
        reset_n      = r;
        bus.os_sel   = os;
        bus.in_valid = v;
        bus.data_in  = d;
        @(posedge clk_div);
        cyc++;
        exp_v = 1'b0;
        if (!r) begin
            prev_os = 3'b000;
            hist_q.delete();
            pend_q.delete();
            acc_cnt = 0;
            last_d = '0;
            last_s = 1'b0;
        end else begin
            if (os == 3'b000 || os == 3'b111 || os != prev_os) begin
                hist_q.delete();
                pend_q.delete();
                acc_cnt = 0;
                if (os == 3'b000 || os == 3'b111) last_s = 1'b0;
            end else if (v) begin
                hist_q.push_back(longint'(signed'(d)));
                while (hist_q.size() > NSTG * DM + 1) void'(hist_q.pop_front());
                if (acc_cnt >= NSTG * DM) pend_q.push_back(model_result(cyc + NSTG, os));
                acc_cnt++;
            end
            prev_os = os;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                pend_t p = pend_q.pop_front();
                exp_v  = 1'b1;
                last_d = p.val;
                last_s = p.sat;
            end
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
        chk("data_out", 32'(bus.data_out), 32'(last_d));
        chk("sat_flag", 32'(bus.sat_flag), 32'(last_s));
        if (bus.out_valid) begin
            obs_q.push_back(bus.data_out);
            obs_sat_q.push_back(bus.sat_flag);
        end
    endtask

    task automatic idle(input logic [2:0] os, input int n);
        for (int i = 0; i < n; i++) step(1'b1, os, 1'b0, 32'd0);
    endtask

    // Feeds scale*n^3 for n = 0..count-1, optionally with random in_valid gaps.
    task automatic stream_cubes(input logic [2:0] os, input longint scale, input int count, input logic gaps);
        int n = 0;
        for (int t = 0; t < count * 20 && n < count; t++) begin
            logic   v  = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            longint nn = longint'(n);
            step(1'b1, os, v, 32'(scale * nn * nn * nn));
            if (v) n++;
        end
    endtask

    function automatic logic [2:0] pick_os();
        int r = $urandom_range(0, 9);
        if (r == 0) return 3'b000;
        else if (r == 1) return 3'b111;
        else return 3'($urandom_range(1, 6));
    endfunction

    initial begin
        logic [2:0] os;
        checks = 0; failures = 0; cyc = 0; acc_cnt = 0;
        prev_os = 3'b000; exp_v = 1'b0; last_d = '0; last_s = 1'b0;
        reset_n = 1'b0; bus.os_sel = 3'b001; bus.in_valid = 1'b0; bus.data_in = '0;

        // Reset held two cycles with in_valid high, then one cycle after release.
        step(1'b0, 3'b001, 1'b1, $urandom);
        step(1'b0, 3'b001, 1'b1, $urandom);
        step(1'b1, 3'b001, 1'b0, 32'd0);

        // Cubic ramp at os_sel=1: steady 192.
        obs_q.delete(); obs_sat_q.delete();
        stream_cubes(3'b001, 64, 16, 1'b0);
        idle(3'b001, 5);
        chk("ramp_count", 32'(obs_q.size()), 32'd13);
        for (int i = 0; i < obs_q.size(); i++) chk("ramp_val", 32'(obs_q[i]), 32'd192);

        // Step input into saturation.
        step(1'b1, 3'b000, 1'b0, 32'd0);
        idle(3'b001, 1);
        obs_q.delete(); obs_sat_q.delete();
        for (int i = 0; i < 3; i++) step(1'b1, 3'b001, 1'b1, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 3'b001, 1'b1, 32'h0010_0000);
        idle(3'b001, 5);
        if (obs_q.size() >= 4) begin
            chk("step_v0", 32'(obs_q[0]), 32'd32767);
            chk("step_s0", 32'(obs_sat_q[0]), 32'd1);
            chk("step_v1", 32'(obs_q[1]), -32'sd32768);
            chk("step_s1", 32'(obs_sat_q[1]), 32'd1);
            chk("step_v2", 32'(obs_q[2]), 32'd32767);
            chk("step_s2", 32'(obs_sat_q[2]), 32'd1);
            chk("step_v3", 32'(obs_q[3]), 32'd0);
            chk("step_s3", 32'(obs_sat_q[3]), 32'd0);
        end else begin
            chk("step_count", 32'(obs_q.size()), 32'd5);
        end

        // os_sel=2 (S=4), 4*n^3.
        idle(3'b010, 1);
        obs_q.delete(); obs_sat_q.delete();
        stream_cubes(3'b010, 4, 12, 1'b0);
        idle(3'b010, 5);
        chk("s4_count", 32'(obs_q.size()), 32'd9);
        if (obs_q.size() > 0) chk("s4_val", 32'(obs_q[obs_q.size()-1]), 32'(EXP_S4));

        // Mid-stream switch from os_sel=1 to 2.
        idle(3'b001, 1);
        stream_cubes(3'b001, 64, 8, 1'b0);
        obs_q.delete(); obs_sat_q.delete();
        stream_cubes(3'b010, 4, 10, 1'b0);
        idle(3'b010, 5);
        chk("switch_count", 32'(obs_q.size()), 32'd6);
        for (int i = 0; i < obs_q.size(); i++) chk("switch_val", 32'(obs_q[i]), 32'(EXP_S4));

        // Gapped input: same value sequence, latency checked per sample by the model.
        step(1'b1, 3'b000, 1'b0, 32'd0);
        idle(3'b001, 1);
        obs_q.delete(); obs_sat_q.delete();
        stream_cubes(3'b001, 64, 16, 1'b1);
        idle(3'b001, 5);
        chk("gap_count", 32'(obs_q.size()), 32'd13);
        for (int i = 0; i < obs_q.size(); i++) chk("gap_val", 32'(obs_q[i]), 32'd192);

        // Reset mid-stream discards in-flight samples.
        stream_cubes(3'b001, 64, 6, 1'b0);
        step(1'b0, 3'b010, 1'b1, 32'd5);
        idle(3'b001, 6);

        // Random traffic with occasional select changes, inactivity and resets.
        os = 3'b001;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] d;
            if ($urandom_range(0, 29) == 0) os = pick_os();
            d = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 4000)) - 32'd2000);
            step(($urandom_range(0, 199) != 0), os, ($urandom_range(0, 9) < 6), d);
        end
        idle(3'b001, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
